// File: rtl/ras_checkpointed.sv
// Checkpointed return address stack: speculative push/pop at fetch, commit on retire, one-cycle rollback on flush.
// Optional RAS_TOP_REPAIR_EN: checkpoints also carry the top entry and flush rewrites the committed top.
module ras_checkpointed #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] new_addr,
  input  logic              branch_fetched,
  input  logic              branch_retired,
  input  logic              flush,
  output logic [ADDR_W-1:0] addr,
  output logic              empty,
  output logic              ckpt_full,
  output logic              ckpt_overflow
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned FIX_W  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int unsigned FCNT_W = FIX_W + 1;

  logic [ADDR_W-1:0] ram_q [DEPTH];
  logic [PTR_W-1:0]  ck_sp_q [MAX_INFLIGHT];
  logic [CNT_W-1:0]  ck_sc_q [MAX_INFLIGHT];

  logic [PTR_W-1:0]  sp_q, sp_d, cp_q, cp_d, spec_sp;
  logic [CNT_W-1:0]  sc_q, sc_d, cc_q, cc_d, spec_sc;
  logic [FIX_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              ovf_q, ovf_d;
  logic              ram_we;
  logic [PTR_W-1:0]  ram_wa;
  logic [ADDR_W-1:0] ram_wd;
  logic              do_cap, do_retire, cap_ok, fifo_full;

`ifdef RAS_TOP_REPAIR_EN
  logic [ADDR_W-1:0] ck_top_q [MAX_INFLIGHT];
  logic [ADDR_W-1:0] ctop_q, ctop_d, cap_top;
`endif

  assign fifo_full = (fcnt_q == FCNT_W'(MAX_INFLIGHT));
  assign do_retire = branch_retired && (fcnt_q != '0);
  assign do_cap    = branch_fetched && !flush;
  assign cap_ok    = do_cap && (!fifo_full || do_retire);

  // Next-state: speculative update, checkpoint FIFO, commit and rollback
  always_comb begin
    spec_sp = sp_q;
    spec_sc = sc_q;
    ram_we  = 1'b0;
    ram_wa  = sp_q;
    ram_wd  = new_addr;
    if (push && !pop) begin
      spec_sp = sp_q + PTR_W'(1);
      spec_sc = (sc_q == CNT_W'(DEPTH)) ? sc_q : sc_q + CNT_W'(1);
      ram_we  = !flush;
      ram_wa  = spec_sp;
    end else if (pop && !push) begin
      if (sc_q != '0) begin
        spec_sp = sp_q - PTR_W'(1);
        spec_sc = sc_q - CNT_W'(1);
      end
    end else if (push && pop) begin
      ram_we = !flush;
      if (sc_q == '0) spec_sc = CNT_W'(1);
    end

    cp_d  = do_retire ? ck_sp_q[rd_q] : cp_q;
    cc_d  = do_retire ? ck_sc_q[rd_q] : cc_q;
    ovf_d = ovf_q | (do_cap && fifo_full && !do_retire);
`ifdef RAS_TOP_REPAIR_EN
    ctop_d  = do_retire ? ck_top_q[rd_q] : ctop_q;
    cap_top = push ? new_addr : ram_q[spec_sp];
`endif

    if (flush) begin
      sp_d   = cp_d;
      sc_d   = cc_d;
      wr_d   = '0;
      rd_d   = '0;
      fcnt_d = '0;
`ifdef RAS_TOP_REPAIR_EN
      ram_we = 1'b1;
      ram_wa = cp_d;
      ram_wd = ctop_d;
`endif
    end else begin
      sp_d   = spec_sp;
      sc_d   = spec_sc;
      wr_d   = wr_q + FIX_W'(cap_ok);
      rd_d   = rd_q + FIX_W'(do_retire);
      fcnt_d = fcnt_q + FCNT_W'(cap_ok) - FCNT_W'(do_retire);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= '0;
      sc_q   <= '0;
      cp_q   <= '0;
      cc_q   <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
`ifdef RAS_TOP_REPAIR_EN
      ctop_q <= '0;
`endif
    end else begin
      sp_q   <= sp_d;
      sc_q   <= sc_d;
      cp_q   <= cp_d;
      cc_q   <= cc_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fcnt_q <= fcnt_d;
      ovf_q  <= ovf_d;
`ifdef RAS_TOP_REPAIR_EN
      ctop_q <= ctop_d;
`endif
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counts
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_wa] <= ram_wd;
    if (cap_ok) begin
      ck_sp_q[wr_q] <= spec_sp;
      ck_sc_q[wr_q] <= spec_sc;
`ifdef RAS_TOP_REPAIR_EN
      ck_top_q[wr_q] <= cap_top;
`endif
    end
  end

  assign addr          = (sc_q != '0) ? ram_q[sp_q] : '0;
  assign empty         = (sc_q == '0);
  assign ckpt_full     = fifo_full;
  assign ckpt_overflow = ovf_q;

endmodule

// File: tb/tb_ras_checkpointed.sv
// Directed self-checking bench for ras_checkpointed (DEPTH=8, ADDR_W=32, MAX_INFLIGHT=4).
module tb_ras_checkpointed;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0, pop = 1'b0;
  logic [31:0] new_addr = '0;
  logic        branch_fetched = 1'b0, branch_retired = 1'b0, flush = 1'b0;
  logic [31:0] addr;
  logic        empty, ckpt_full, ckpt_overflow;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  ras_checkpointed #(.DEPTH(8), .ADDR_W(32), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .new_addr(new_addr),
    .branch_fetched(branch_fetched), .branch_retired(branch_retired), .flush(flush),
    .addr(addr), .empty(empty), .ckpt_full(ckpt_full), .ckpt_overflow(ckpt_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic p, input logic po, input logic [31:0] a,
                      input logic bf, input logic br, input logic fl);
    push = p; pop = po; new_addr = a;
    branch_fetched = bf; branch_retired = br; flush = fl;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; new_addr = '0;
    branch_fetched = 1'b0; branch_retired = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_addr", 64'(addr), 64'h0);
    chk("rst_empty", 64'(empty), 64'h1);
    chk("rst_full", 64'(ckpt_full), 64'h0);
    chk("rst_ovf", 64'(ckpt_overflow), 64'h0);

    // Basic push/pop with an ignored pop on empty
    step(1, 0, 32'h100, 0, 0, 0);
    step(1, 0, 32'h200, 0, 0, 0);
    chk("push2_addr", 64'(addr), 64'h200);
    chk("push2_empty", 64'(empty), 64'h0);
    step(0, 1, 0, 0, 0, 0);
    chk("pop1_addr", 64'(addr), 64'h100);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("pop3_addr", 64'(addr), 64'h0);
    chk("pop3_empty", 64'(empty), 64'h1);
    chk("pop3_sp", 64'(dut.sp_q), 64'h0);

    // Saturation and wrap at DEPTH=8
    do_reset();
    for (int i = 1; i <= 9; i++) step(1, 0, 32'(i), 0, 0, 0);
    chk("sat_sc", 64'(dut.sc_q), 64'h8);
    chk("sat_addr", 64'(addr), 64'h9);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_%0d", i), 64'(addr), 64'(9 - i));
      step(0, 1, 0, 0, 0, 0);
    end
    chk("drain_empty", 64'(empty), 64'h1);

    // Commit then flush away wrong-path pushes
    do_reset();
    step(1, 0, 32'hA, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("commit_cc", 64'(dut.cc_q), 64'h1);
    step(1, 0, 32'hB, 1, 0, 0);
    step(1, 0, 32'hC, 1, 0, 0);
    chk("pre_flush_addr", 64'(addr), 64'hC);
    step(0, 0, 0, 0, 0, 1);
    chk("flush_addr", 64'(addr), 64'hA);
    chk("flush_sc", 64'(dut.sc_q), 64'h1);
    chk("flush_fifo_clr", 64'(ckpt_full), 64'h0);

    // Simultaneous push and pop replaces the top
    do_reset();
    step(1, 0, 32'h10, 0, 0, 0);
    step(1, 1, 32'h55, 0, 0, 0);
    chk("pp_addr", 64'(addr), 64'h55);
    chk("pp_sc", 64'(dut.sc_q), 64'h1);

    // Checkpoint FIFO full, concurrent capture/retire, sticky overflow
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
    chk("three_not_full", 64'(ckpt_full), 64'h0);
    step(0, 0, 0, 1, 0, 0);
    chk("four_full", 64'(ckpt_full), 64'h1);
    step(0, 0, 0, 1, 1, 0);
    chk("capret_full", 64'(ckpt_full), 64'h1);
    chk("capret_ovf", 64'(ckpt_overflow), 64'h0);
    step(0, 0, 0, 1, 0, 0);
    chk("ovf_set", 64'(ckpt_overflow), 64'h1);
    step(0, 0, 0, 0, 0, 1);
    chk("ovf_sticky", 64'(ckpt_overflow), 64'h1);
    chk("flush_not_full", 64'(ckpt_full), 64'h0);
    do_reset();
    chk("ovf_rst", 64'(ckpt_overflow), 64'h0);

    // Committed top clobbered by wrap-around, then flush
    step(1, 0, 32'h77, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 32'h80 + 32'(i), 0, 0, 0);
    chk("wrap_top", 64'(addr), 64'h87);
    step(0, 0, 0, 0, 0, 1);
`ifdef RAS_TOP_REPAIR_EN
    chk("repair_addr", 64'(addr), 64'h77);
`else
    chk("norepair_addr", 64'(addr), 64'h87);
`endif
    chk("repair_sc", 64'(dut.sc_q), 64'h1);

    // Reset mid-operation drops stack contents
    step(1, 0, 32'h99, 1, 0, 0);
    rst = 1'b1; #1;
    chk("async_rst_empty", 64'(empty), 64'h1);
    chk("async_rst_addr", 64'(addr), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
